seconds_display: RTL and testbench



---
 rtl/seconds_display_if.sv | 14 +
 rtl/seconds_display.sv | 133 +++++++++++++
 tb/tb_seconds_display.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/seconds_display_if.sv
// Bus between the stopwatch (master) and the seconds display (slave):
// the binary count goes in, packed BCD, segment drive and busy come back.
interface seconds_display_if #(
  parameter int SECONDS_WIDTH = 8,
  parameter int DIGITS        = 3
);
  logic [SECONDS_WIDTH-1:0] seconds_in;
  logic [4*DIGITS-1:0]      bcd_out;
  logic [7*DIGITS-1:0]      hex_out;
  logic                     busy;

  modport master (output seconds_in, input bcd_out, hex_out, busy);
  modport slave  (input seconds_in, output bcd_out, hex_out, busy);
endinterface

// File: rtl/seconds_display.sv
// Sequential double-dabble binary-to-BCD converter that drives active-low
// seven-segment displays, optionally blanking leading zero digits.
module seconds_display #(
  parameter int SECONDS_WIDTH = 8,
  parameter int DIGITS        = 3,
  parameter int BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              async_reset,
  seconds_display_if.slave  bus
);

  localparam int STEP_W = $clog2(SECONDS_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  state_t                   state_r;
  logic [SECONDS_WIDTH-1:0] last_value_r;
  logic [SECONDS_WIDTH-1:0] bin_sh_r;
  logic [4*DIGITS-1:0]      bcd_sh_r;
  logic [STEP_W-1:0]        step_r;
  logic [4*DIGITS-1:0]      bcd_adj_s;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  // Walk from the top digit down; a display stays blank while every digit at
  // or above it is zero, and display 0 always shows its digit.
  function automatic logic [7*DIGITS-1:0] decode_all(input logic [4*DIGITS-1:0] bcd);
    logic [7*DIGITS-1:0] segs;
    logic                lead;
    segs = '0;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        lead = 1'b0;
      end else begin
        lead = lead;
      end
      if ((BLANK_LEADING != 0) && lead && (i > 0)) begin
        segs[7*i +: 7] = 7'h7F;
      end else begin
        segs[7*i +: 7] = seg7(bcd[4*i +: 4]);
      end
    end
    return segs;
  endfunction

  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] bcd);
    logic [4*DIGITS-1:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  // Nibble correction ahead of each shift
  always_comb begin
    bcd_adj_s = add3(bcd_sh_r);
  end

  // Conversion FSM with registered BCD and segment outputs
  always_ff @(posedge clk) begin
    if (!async_reset) begin
      state_r      <= IDLE;
      last_value_r <= '0;
      bin_sh_r     <= '0;
      bcd_sh_r     <= '0;
      step_r       <= '0;
      bus.bcd_out  <= '0;
      bus.hex_out  <= decode_all('0);
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.seconds_in != last_value_r) begin
            bin_sh_r     <= bus.seconds_in;
            last_value_r <= bus.seconds_in;
            bcd_sh_r     <= '0;
            step_r       <= '0;
            state_r      <= CONVERT;
          end else begin
            state_r <= IDLE;
          end
        end
        CONVERT: begin
          bcd_sh_r <= {bcd_adj_s[4*DIGITS-2:0], bin_sh_r[SECONDS_WIDTH-1]};
          bin_sh_r <= {bin_sh_r[SECONDS_WIDTH-2:0], 1'b0};
          step_r   <= step_r + {{(STEP_W-1){1'b0}}, 1'b1};
          if (step_r == STEP_W'(SECONDS_WIDTH - 1)) begin
            state_r <= LOAD;
          end else begin
            state_r <= CONVERT;
          end
        end
        LOAD: begin
          bus.bcd_out <= bcd_sh_r;
          bus.hex_out <= decode_all(bcd_sh_r);
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state_r != IDLE);

endmodule

// File: tb/tb_seconds_display.sv
// Directed bench for seconds_display: one instance with leading-zero blanking
// and one without, both fed the same seconds value.
module tb_seconds_display;

  logic clk;
  logic async_reset;
  int   checks;
  int   errors;
  int   n;

  seconds_display_if #(.SECONDS_WIDTH(8), .DIGITS(3)) bus_a ();
  seconds_display_if #(.SECONDS_WIDTH(8), .DIGITS(3)) bus_b ();

  seconds_display #(.SECONDS_WIDTH(8), .DIGITS(3), .BLANK_LEADING(1)) dut_a (
    .clk(clk), .async_reset(async_reset), .bus(bus_a)
  );
  seconds_display #(.SECONDS_WIDTH(8), .DIGITS(3), .BLANK_LEADING(0)) dut_b (
    .clk(clk), .async_reset(async_reset), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_val(input logic [7:0] v);
    bus_a.seconds_in = v;
    bus_b.seconds_in = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts cycles of busy high on dut_a, bounded
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (bus_a.busy === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    async_reset = 1'b0;
    set_val(8'd0);
    tick();
    tick();
    async_reset = 1'b1;
    check("reset_hex_a", 32'(bus_a.hex_out), 32'({7'h7F, 7'h7F, 7'h40}));
    check("reset_hex_b", 32'(bus_b.hex_out), 32'({7'h40, 7'h40, 7'h40}));
    check("reset_bcd", 32'(bus_a.bcd_out), 32'h000);
    check("reset_busy", 32'(bus_a.busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_busy", 32'(bus_a.busy), 32'd0);
    end

    // 0 -> 1
    set_val(8'd1);
    tick();
    wait_idle(n);
    check("busy_len_1", 32'(n), 32'd9);
    check("bcd_1", 32'(bus_a.bcd_out), 32'h001);
    check("hex_1_a", 32'(bus_a.hex_out), 32'({7'h7F, 7'h7F, 7'h79}));
    check("hex_1_b", 32'(bus_b.hex_out), 32'({7'h40, 7'h40, 7'h79}));

    set_val(8'd255);
    tick();
    wait_idle(n);
    check("busy_len_255", 32'(n), 32'd9);
    check("bcd_255", 32'(bus_a.bcd_out), 32'h255);
    check("hex_255", 32'(bus_a.hex_out), 32'({7'h24, 7'h12, 7'h12}));

    set_val(8'd100);
    tick();
    wait_idle(n);
    check("bcd_100", 32'(bus_a.bcd_out), 32'h100);
    check("hex_100_a", 32'(bus_a.hex_out), 32'({7'h79, 7'h40, 7'h40}));
    check("hex_100_b", 32'(bus_b.hex_out), 32'({7'h79, 7'h40, 7'h40}));

    set_val(8'd7);
    tick();
    wait_idle(n);
    check("bcd_7", 32'(bus_b.bcd_out), 32'h007);
    check("hex_7_a", 32'(bus_a.hex_out), 32'({7'h7F, 7'h7F, 7'h78}));
    check("hex_7_b", 32'(bus_b.hex_out), 32'({7'h40, 7'h40, 7'h78}));

    // 12, then 34 arriving mid-conversion
    set_val(8'd12);
    tick();
    check("busy_rise_12", 32'(bus_a.busy), 32'd1);
    tick();
    tick();
    tick();
    set_val(8'd34);
    check("hold_during_conv", 32'(bus_a.bcd_out), 32'h007);
    wait_idle(n);
    check("bcd_12", 32'(bus_a.bcd_out), 32'h012);
    check("hex_12", 32'(bus_a.hex_out), 32'({7'h7F, 7'h79, 7'h24}));
    check("idle_gap", 32'(bus_a.busy), 32'd0);
    tick();
    check("busy_rise_34", 32'(bus_a.busy), 32'd1);
    wait_idle(n);
    check("busy_len_34", 32'(n), 32'd9);
    check("bcd_34", 32'(bus_a.bcd_out), 32'h034);
    check("hex_34", 32'(bus_a.hex_out), 32'({7'h7F, 7'h30, 7'h19}));

    // reset in the middle of converting 200
    set_val(8'd200);
    tick();
    tick();
    tick();
    async_reset = 1'b0;
    tick();
    check("midrst_busy", 32'(bus_a.busy), 32'd0);
    check("midrst_bcd", 32'(bus_a.bcd_out), 32'h000);
    check("midrst_hex_a", 32'(bus_a.hex_out), 32'({7'h7F, 7'h7F, 7'h40}));
    check("midrst_hex_b", 32'(bus_b.hex_out), 32'({7'h40, 7'h40, 7'h40}));
    async_reset = 1'b1;
    tick();
    check("busy_rise_200", 32'(bus_a.busy), 32'd1);
    wait_idle(n);
    check("busy_len_200", 32'(n), 32'd9);
    check("bcd_200", 32'(bus_a.bcd_out), 32'h200);
    check("hex_200", 32'(bus_a.hex_out), 32'({7'h24, 7'h40, 7'h40}));
    tick();
    check("stay_idle_200", 32'(bus_a.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
